// File: rtl/laplace_pkg.sv
// Shared widths, result payload and the saturate/abs reduction for the Laplacian pipe.
package laplace_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned SUM_W   = 9;
  localparam int unsigned NB_W    = 10;
  localparam int unsigned DIFF_W  = 11;
  localparam int unsigned PIX_MAX = 255;

  typedef struct packed {
    logic             sat;
    logic [PIX_W-1:0] pix;
  } pix_res_t;

  // Reduce a signed difference to a pixel; negatives clamp to 0 or fold to |d|.
  function automatic pix_res_t sat_pix(input logic signed [DIFF_W-1:0] d,
                                       input logic                     abs_en);
    pix_res_t                  r;
    logic signed [DIFF_W-1:0]  mag;
    r   = '0;
    mag = d[DIFF_W-1] ? -d : d;
    if (d[DIFF_W-1] && !abs_en) begin
      r.sat = 1'b1;
      r.pix = '0;
    end else if (mag > $signed(DIFF_W'(PIX_MAX))) begin
      r.sat = 1'b1;
      r.pix = PIX_W'(PIX_MAX);
    end else begin
      r.pix = mag[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/laplace_kernel_pipe_add8.sv
// 8-bit adder with optional OR-approximated LSBs (APPROX_ADD_EN); exact a+b+cin otherwise.
module approx_add8
  import laplace_pkg::*;
#(
  parameter int unsigned APPROX_BITS = 1
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic             cin_i,
  output logic [PIX_W-1:0] s_o,
  output logic             cout_o
);

`ifdef APPROX_ADD_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  localparam int unsigned LOW_BITS = APPROX_EN ? APPROX_BITS : 0;

  if (LOW_BITS == 0) begin : g_exact
    assign {cout_o, s_o} = SUM_W'(a_i) + SUM_W'(b_i) + SUM_W'(cin_i);
  end else begin : g_approx
    localparam int unsigned HI_W = PIX_W - LOW_BITS + 1;
    logic [HI_W-1:0] hi;
    // Low bits are a|b and never carry; only the upper slice ripples.
    assign hi     = HI_W'(a_i[PIX_W-1:LOW_BITS]) + HI_W'(b_i[PIX_W-1:LOW_BITS])
                  + HI_W'(cin_i);
    assign s_o    = {hi[HI_W-2:0], a_i[LOW_BITS-1:0] | b_i[LOW_BITS-1:0]};
    assign cout_o = hi[HI_W-1];
  end

endmodule

// File: rtl/laplace_kernel_pipe.sv
// 3-stage 4-neighbour Laplacian (4C - N - S - E - W) with valid/ready on both sides.
// Build option: APPROX_ADD_EN selects the approximate S1 neighbour adders.
module laplace_kernel_pipe
  import laplace_pkg::*;
#(
  parameter int unsigned APPROX_BITS = 1,
  parameter int unsigned ABS_OUT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pix_n,
  input  logic [PIX_W-1:0] pix_s,
  input  logic [PIX_W-1:0] pix_e,
  input  logic [PIX_W-1:0] pix_w,
  input  logic [PIX_W-1:0] pix_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sat
);

  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [SUM_W-1:0]  ns_q, ns_d, ew_q, ew_d;
  logic [NB_W-1:0]   c4a_q, c4a_d, c4b_q, c4b_d, nb_q, nb_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              sat_q, sat_d;

  logic              rdy1, rdy2, rdy3;
  logic [SUM_W-1:0]  ns_c, ew_c;
  logic signed [DIFF_W-1:0] diff_c;
  pix_res_t          res_c;

  // Ready ripples back so bubbles anywhere in the pipe collapse.
  assign rdy3     = ~v3_q | out_ready;
  assign rdy2     = ~v2_q | rdy3;
  assign rdy1     = ~v1_q | rdy2;
  assign in_ready = rdy1;

  approx_add8 #(.APPROX_BITS(APPROX_BITS)) u_add_ns (
    .a_i(pix_n), .b_i(pix_s), .cin_i(1'b0), .s_o(ns_c[PIX_W-1:0]), .cout_o(ns_c[PIX_W])
  );

  approx_add8 #(.APPROX_BITS(APPROX_BITS)) u_add_ew (
    .a_i(pix_e), .b_i(pix_w), .cin_i(1'b0), .s_o(ew_c[PIX_W-1:0]), .cout_o(ew_c[PIX_W])
  );

  assign diff_c = $signed({1'b0, c4b_q}) - $signed({1'b0, nb_q});
  assign res_c  = sat_pix(diff_c, ABS_OUT != 0);

  // Each stage loads only on its own transfer; otherwise it holds.
  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    ns_d  = ns_q;
    ew_d  = ew_q;
    c4a_d = c4a_q;
    c4b_d = c4b_q;
    nb_d  = nb_q;
    pix_d = pix_q;
    sat_d = sat_q;

    if (rdy1) v1_d = in_valid;
    if (in_valid && rdy1) begin
      ns_d  = ns_c;
      ew_d  = ew_c;
      c4a_d = {pix_c, 2'b00};
    end

    if (rdy2) v2_d = v1_q;
    if (v1_q && rdy2) begin
      nb_d  = NB_W'(ns_q) + NB_W'(ew_q);
      c4b_d = c4a_q;
    end

    if (rdy3) v3_d = v2_q;
    if (v2_q && rdy3) begin
      pix_d = res_c.pix;
      sat_d = res_c.sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ns_q  <= '0;
      ew_q  <= '0;
      c4a_q <= '0;
      c4b_q <= '0;
      nb_q  <= '0;
      pix_q <= '0;
      sat_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      ns_q  <= ns_d;
      ew_q  <= ew_d;
      c4a_q <= c4a_d;
      c4b_q <= c4b_d;
      nb_q  <= nb_d;
      pix_q <= pix_d;
      sat_q <= sat_d;
    end
  end

  assign out_valid = v3_q;
  assign out_pix   = pix_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_laplace_kernel_pipe.sv
// Self-checking bench for laplace_kernel_pipe: directed table, reset, stall, bubble and random traffic.
module tb_laplace_kernel_pipe;

  localparam int unsigned AB = 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, in_ready_a;
  logic [7:0] pix_n, pix_s, pix_e, pix_w, pix_c;
  logic       out_valid, out_ready, out_sat;
  logic [7:0] out_pix;
  logic       out_valid_a, out_sat_a;
  logic [7:0] out_pix_a;

  laplace_kernel_pipe #(.APPROX_BITS(AB), .ABS_OUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pix_n(pix_n), .pix_s(pix_s), .pix_e(pix_e), .pix_w(pix_w), .pix_c(pix_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_sat(out_sat)
  );

  laplace_kernel_pipe #(.APPROX_BITS(AB), .ABS_OUT(1)) dut_abs (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .pix_n(pix_n), .pix_s(pix_s), .pix_e(pix_e), .pix_w(pix_w), .pix_c(pix_c),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pix(out_pix_a), .out_sat(out_sat_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int pix0; int sat0; int pix1; int sat1; } exp_t;
  typedef struct { int c; int n; int s; int e; int w; int pix0; int sat0; int pix1; int sat1; } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   out_log[$];
  bit   hold_pend = 0;
  int   prev_pix, prev_sat;
  bit   last_in_fire, last_out_fire, last_in_ready;
  int   cap_pix, cap_sat, cap_pix_a, cap_sat_a;

  // Neighbour-pair sum as the S1 adder should produce it.
  function automatic int add8_ref(int a, int b);
`ifdef APPROX_ADD_EN
    if (AB != 0) return (((a >> AB) + (b >> AB)) << AB) + ((a | b) & ((1 << AB) - 1));
`endif
    return a + b;
  endfunction

  function automatic exp_t lap_ref(int c, int n, int s, int e, int w);
    exp_t r;
    int   d, mag;
    d      = 4 * c - (add8_ref(n, s) + add8_ref(e, w));
    r.pix0 = (d > 255) ? 255 : ((d < 0) ? 0 : d);
    r.sat0 = (d > 255 || d < 0) ? 1 : 0;
    mag    = (d < 0) ? -d : d;
    r.pix1 = (mag > 255) ? 255 : mag;
    r.sat1 = (mag > 255) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: observe handshakes at negedge, score outputs, then advance past posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_pix", int'(out_pix), prev_pix);
      chk("hold_sat", int'(out_sat), prev_sat);
    end
    last_in_ready = in_ready;
    last_out_fire = out_valid && out_ready;
    last_in_fire  = in_valid && in_ready;
    if (last_out_fire) begin
      cap_pix   = int'(out_pix);
      cap_sat   = int'(out_sat);
      cap_pix_a = int'(out_pix_a);
      cap_sat_a = int'(out_sat_a);
      out_log.push_back(cap_pix);
      chk("abs_valid", int'(out_valid_a), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pix", cap_pix, e.pix0);
        chk("sb_sat", cap_sat, e.sat0);
        chk("sb_abs_pix", cap_pix_a, e.pix1);
        chk("sb_abs_sat", cap_sat_a, e.sat1);
      end
    end
    if (last_in_fire) begin
      chk("abs_ready", int'(in_ready_a), 1);
      exp_q.push_back(lap_ref(int'(pix_c), int'(pix_n), int'(pix_s), int'(pix_e), int'(pix_w)));
    end
    hold_pend = out_valid && !out_ready;
    prev_pix  = int'(out_pix);
    prev_sat  = int'(out_sat);
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(int c, int n, int s, int e, int w);
    pix_c = 8'(c); pix_n = 8'(n); pix_s = 8'(s); pix_e = 8'(e); pix_w = 8'(w);
  endtask

  task automatic drain(string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) step();
    chk(name, exp_q.size(), 0);
  endtask

  vec_t tbl[11];

  initial begin
    int  lat, k, acc, quiet;
    bit  saw_drop;

    tbl[0]  = '{10, 5, 5, 5, 5, 20, 0, 20, 0};
`ifdef APPROX_ADD_EN
    tbl[0]  = '{10, 5, 5, 5, 5, 22, 0, 22, 0};
`endif
    tbl[1]  = '{255, 0, 0, 0, 0, 255, 1, 255, 1};
    tbl[2]  = '{0, 255, 255, 255, 255, 0, 1, 255, 1};
    tbl[3]  = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
`ifdef APPROX_ADD_EN
    tbl[3]  = '{1, 1, 1, 1, 1, 2, 0, 2, 0};
`endif
    tbl[4]  = '{100, 10, 20, 30, 40, 255, 1, 255, 1};
    tbl[5]  = '{50, 100, 100, 0, 2, 0, 1, 2, 0};
    tbl[6]  = '{64, 64, 64, 64, 64, 0, 0, 0, 0};
    tbl[7]  = '{80, 16, 16, 16, 16, 255, 1, 255, 1};
    tbl[8]  = '{80, 16, 16, 16, 18, 254, 0, 254, 0};
    tbl[9]  = '{10, 200, 100, 2, 0, 0, 1, 255, 1};
    tbl[10] = '{10, 200, 40, 2, 0, 0, 1, 202, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_pix(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // Directed table with latency measurement.
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      set_pix(tbl[i].c, tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w);
      in_valid = 1'b1;
      step();
      chk($sformatf("tbl%0d_accept", i), int'(last_in_fire), 1);
      in_valid = 1'b0;
      lat = 0;
      for (int t = 1; t <= 8 && lat == 0; t++) begin
        step();
        if (last_out_fire) lat = t;
      end
      chk($sformatf("tbl%0d_latency", i), lat, 3);
      chk($sformatf("tbl%0d_pix", i), cap_pix, tbl[i].pix0);
      chk($sformatf("tbl%0d_sat", i), cap_sat, tbl[i].sat0);
      chk($sformatf("tbl%0d_abs_pix", i), cap_pix_a, tbl[i].pix1);
      chk($sformatf("tbl%0d_abs_sat", i), cap_sat_a, tbl[i].sat1);
    end

    // Reset while the pipe is full: in-flight items must vanish.
    set_pix(10, 5, 5, 5, 5);
    in_valid = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_pix", int'(out_pix), 0);
    exp_q.delete();
    hold_pend = 1'b0;
    in_valid  = 1'b0;
    #2;
    rst_n = 1'b1;
    quiet = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (last_out_fire) quiet++;
    end
    chk("post_rst_outputs", quiet, 0);

    // Backpressure: six back-to-back items, sink stalls for cycles 4..7.
    out_log.delete();
    k = 1;
    saw_drop = 1'b0;
    for (int cyc = 0; cyc < 40 && out_log.size() < 6; cyc++) begin
      in_valid  = (k <= 6);
      set_pix(k, 0, 0, 0, 0);
      out_ready = !(cyc >= 4 && cyc <= 7);
      step();
      if (in_valid && !last_in_ready) saw_drop = 1'b1;
      if (last_in_fire) k++;
    end
    chk("bp_in_ready_drop", int'(saw_drop), 1);
    chk("bp_count", out_log.size(), 6);
    for (int j = 0; j < 6 && j < out_log.size(); j++)
      chk($sformatf("bp_out%0d", j), out_log[j], 4 * (j + 1));
    drain("bp_drain");

    // Bubble collapse: sparse input with sink blocked still fills all three stages.
    out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc % 2 == 0);
      set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
      step();
      if (last_in_fire) acc++;
    end
    chk("bubble_accepts", acc, 3);
    chk("bubble_in_ready", int'(last_in_ready), 0);
    drain("bubble_drain");

    // Random traffic against the reference model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       set_pix(255, 0, 0, 0, 0);
        1:       set_pix(0, 255, 255, 255, 255);
        default: set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255), $urandom_range(0, 255));
      endcase
      step();
    end
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
